// File: rtl/traffic_light_pkg.sv
// Shared state codes, lamp encodings and the lamp decode for the intersection controller.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    ST_ALLRED    = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_PED_WALK  = 3'd5,
    ST_FLASH     = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } lamps_t;

  // Moore decode of a state (plus flash phase) into both lamp heads and the walk signal.
  function automatic lamps_t decode_lamps(input state_t s, input logic flash_on);
    lamps_t l;
    l.ns   = LAMP_RED;
    l.ew   = LAMP_RED;
    l.walk = 1'b0;
    case (s)
      ST_NS_GREEN:  l.ns = LAMP_GRN;
      ST_NS_YELLOW: l.ns = LAMP_YEL;
      ST_EW_GREEN:  l.ew = LAMP_GRN;
      ST_EW_YELLOW: l.ew = LAMP_YEL;
      ST_PED_WALK:  l.walk = 1'b1;
      ST_FLASH: begin
        l.ns = flash_on ? LAMP_YEL : LAMP_OFF;
        l.ew = flash_on ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Phase up-counter with clear-on-entry, end-of-phase compare and minimum-green compare.
module phase_timer #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_GREEN_CYC = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] duration,
  output logic             done_c,
  output logic             min_reached_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A phase of duration D ends in the cycle where cnt reaches D-1.
  always_comb begin
    done_c        = (cnt == (duration - CNT_W'(1)));
    min_reached_c = (cnt >= CNT_W'(MIN_GREEN_CYC - 1));
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: timed green/yellow/all-red cycle, pedestrian walk, night flash.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int unsigned GREEN_NS_CYC  = 300,
  parameter int unsigned GREEN_EW_CYC  = 200,
  parameter int unsigned YELLOW_CYC    = 50,
  parameter int unsigned ALLRED_CYC    = 20,
  parameter int unsigned MIN_GREEN_CYC = 60,
  parameter int unsigned WALK_CYC      = 100,
  parameter int unsigned FLASH_CYC     = 25,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       night_mode,
  input  logic       ped_req,
  output logic [2:0] NS_light,
  output logic [2:0] EW_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  state_t           state, state_next;
  logic             dir, dir_next;
  logic             ped_pend, ped_pend_next;
  logic             flash_on, flash_on_next;
  logic [CNT_W-1:0] duration_c;
  logic             timer_clear_c;
  logic             done_c;
  logic             min_reached_c;
  lamps_t           lamps_next_c;

  phase_timer #(
    .CNT_W         (CNT_W),
    .MIN_GREEN_CYC (MIN_GREEN_CYC)
  ) u_phase_timer (
    .clk           (clk),
    .reset         (reset),
    .clear         (timer_clear_c),
    .duration      (duration_c),
    .done_c        (done_c),
    .min_reached_c (min_reached_c)
  );

  // Duration of the current phase; in FLASH it is the toggle half-period.
  always_comb begin
    duration_c = CNT_W'(ALLRED_CYC);
    case (state)
      ST_NS_GREEN:  duration_c = CNT_W'(GREEN_NS_CYC);
      ST_EW_GREEN:  duration_c = CNT_W'(GREEN_EW_CYC);
      ST_NS_YELLOW,
      ST_EW_YELLOW: duration_c = CNT_W'(YELLOW_CYC);
      ST_PED_WALK:  duration_c = CNT_W'(WALK_CYC);
      ST_FLASH:     duration_c = CNT_W'(FLASH_CYC);
      default:      duration_c = CNT_W'(ALLRED_CYC);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_ALLRED;
      dir      <= 1'b0;
      ped_pend <= 1'b0;
      flash_on <= 1'b0;
    end else begin
      state    <= state_next;
      dir      <= dir_next;
      ped_pend <= ped_pend_next;
      flash_on <= flash_on_next;
    end
  end

  always_comb begin
    state_next    = state;
    dir_next      = dir;
    ped_pend_next = ped_pend;
    flash_on_next = flash_on;

    case (state)
      ST_ALLRED: begin
        if (done_c) begin
          if (night_mode)  state_next = ST_FLASH;
          else if (dir)    state_next = ST_EW_GREEN;
          else             state_next = ST_NS_GREEN;
        end
      end
      ST_NS_GREEN: begin
        if (done_c || (ped_pend && min_reached_c)) state_next = ST_NS_YELLOW;
      end
      ST_NS_YELLOW: begin
        if (done_c) begin
          dir_next   = 1'b1;
          state_next = ped_pend ? ST_PED_WALK : ST_ALLRED;
        end
      end
      ST_EW_GREEN: begin
        if (done_c || (ped_pend && min_reached_c)) state_next = ST_EW_YELLOW;
      end
      ST_EW_YELLOW: begin
        if (done_c) begin
          dir_next   = 1'b0;
          state_next = ped_pend ? ST_PED_WALK : ST_ALLRED;
        end
      end
      ST_PED_WALK: begin
        if (done_c) state_next = ST_ALLRED;
      end
      ST_FLASH: begin
        if (!night_mode) begin
          state_next = ST_ALLRED;
          dir_next   = 1'b0;
        end else if (done_c) begin
          flash_on_next = ~flash_on;
        end
      end
      default: state_next = ST_ALLRED;
    endcase

    if ((state_next == ST_FLASH) && (state != ST_FLASH)) flash_on_next = 1'b1;

    // Entry into walk or flash consumes the request; a new press on the same edge wins.
    if (((state_next == ST_PED_WALK) || (state_next == ST_FLASH)) && (state_next != state))
      ped_pend_next = 1'b0;
    if (ped_req && (state != ST_FLASH)) ped_pend_next = 1'b1;
  end

  // Counter restarts on every state change and on each flash half-period wrap.
  assign timer_clear_c = (state_next != state) || ((state == ST_FLASH) && done_c);

  // Outputs registered from the next-state decode, so lamps track the state register with no lag.
  assign lamps_next_c = decode_lamps(state_next, flash_on_next);

  always_ff @(posedge clk) begin
    if (!reset) begin
      NS_light <= LAMP_RED;
      EW_light <= LAMP_RED;
      ped_walk <= 1'b0;
      phase    <= 3'd0;
    end else begin
      NS_light <= lamps_next_c.ns;
      EW_light <= lamps_next_c.ew;
      ped_walk <= lamps_next_c.walk;
      phase    <= state_next;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl using short durations and hand-derived phase timelines.
module tb_traffic_light_ctrl;

  localparam logic [2:0] AR  = 3'd0;
  localparam logic [2:0] NSG = 3'd1;
  localparam logic [2:0] NSY = 3'd2;
  localparam logic [2:0] EWG = 3'd3;
  localparam logic [2:0] EWY = 3'd4;
  localparam logic [2:0] PW  = 3'd5;
  localparam logic [2:0] FL  = 3'd6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       night_mode = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] NS_light;
  logic [2:0] EW_light;
  logic       ped_walk;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_light_ctrl #(
    .GREEN_NS_CYC  (20),
    .GREEN_EW_CYC  (12),
    .YELLOW_CYC    (4),
    .ALLRED_CYC    (2),
    .MIN_GREEN_CYC (5),
    .WALK_CYC      (8),
    .FLASH_CYC     (3),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .night_mode (night_mode),
    .ped_req    (ped_req),
    .NS_light   (NS_light),
    .EW_light   (EW_light),
    .ped_walk   (ped_walk),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected lamps for a non-flash phase, written straight from the decode table.
  task automatic check_state(input logic [2:0] p, input string tag);
    logic [2:0] ens, eew;
    ens = (p == NSG) ? 3'b001 : (p == NSY) ? 3'b010 : 3'b100;
    eew = (p == EWG) ? 3'b001 : (p == EWY) ? 3'b010 : 3'b100;
    check({tag, ".phase"}, 32'(phase), 32'(p));
    check({tag, ".ns"}, 32'(NS_light), 32'(ens));
    check({tag, ".ew"}, 32'(EW_light), 32'(eew));
    check({tag, ".walk"}, 32'(ped_walk), (p == PW) ? 32'd1 : 32'd0);
  endtask

  task automatic hold(input logic [2:0] p, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check_state(p, tag);
      step();
    end
  endtask

  task automatic hold_flash(input logic on, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check({tag, ".phase"}, 32'(phase), 32'(FL));
      check({tag, ".ns"}, 32'(NS_light), on ? 32'h2 : 32'h0);
      check({tag, ".ew"}, 32'(EW_light), on ? 32'h4 : 32'h0);
      check({tag, ".walk"}, 32'(ped_walk), 32'd0);
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and the nominal 44-cycle period.
    repeat (10) step();
    check_state(AR, "reset");
    reset = 1'b1;
    hold(AR, 2, "nom_ar0");
    hold(NSG, 20, "nom_nsg");
    hold(NSY, 4, "nom_nsy");
    hold(AR, 2, "nom_ar1");
    hold(EWG, 12, "nom_ewg");
    hold(EWY, 4, "nom_ewy");

    // Request one cycle before NS green entry: minimum green then walk.
    hold(AR, 1, "pre_ar");
    ped_req = 1'b1;
    check_state(AR, "pre_ar_last");
    step();
    ped_req = 1'b0;
    hold(NSG, 5, "pre_nsg_cut");
    hold(NSY, 4, "pre_nsy");
    hold(PW, 8, "pre_walk");
    hold(AR, 2, "pre_ar2");
    hold(EWG, 12, "pre_ewg");
    hold(EWY, 4, "pre_ewy");
    hold(AR, 2, "pre_ar3");

    // Request during NS yellow: yellow completes, walk, then full EW green.
    hold(NSG, 20, "yel_nsg");
    hold(NSY, 1, "yel_nsy0");
    ped_req = 1'b1;
    hold(NSY, 1, "yel_nsy1");
    ped_req = 1'b0;
    hold(NSY, 2, "yel_nsy2");
    hold(PW, 8, "yel_walk");
    hold(AR, 2, "yel_ar");
    hold(EWG, 12, "yel_ewg_full");
    hold(EWY, 4, "yel_ewy");
    hold(AR, 2, "yel_ar2");

    // Request during walk: walk unchanged, next EW green cut at 5, second walk.
    hold(NSG, 20, "walk_nsg");
    hold(NSY, 1, "walk_nsy0");
    ped_req = 1'b1;
    hold(NSY, 1, "walk_nsy1");
    ped_req = 1'b0;
    hold(NSY, 2, "walk_nsy2");
    hold(PW, 3, "walk_pw0");
    ped_req = 1'b1;
    hold(PW, 1, "walk_pw1");
    ped_req = 1'b0;
    hold(PW, 4, "walk_pw2");
    hold(AR, 2, "walk_ar");
    hold(EWG, 5, "walk_ewg_cut");
    hold(EWY, 4, "walk_ewy");
    hold(PW, 8, "walk_pw_second");
    hold(AR, 2, "walk_ar2");

    // Night mode: green runs full, flash 3-cycle halves, ped ignored, exit to NS green.
    hold(NSG, 3, "night_nsg0");
    night_mode = 1'b1;
    hold(NSG, 17, "night_nsg1");
    hold(NSY, 4, "night_nsy");
    hold(AR, 2, "night_ar");
    hold_flash(1'b1, 3, "flash_on0");
    hold_flash(1'b0, 1, "flash_off0");
    ped_req = 1'b1;
    hold_flash(1'b0, 1, "flash_off1");
    ped_req = 1'b0;
    hold_flash(1'b0, 1, "flash_off2");
    hold_flash(1'b1, 3, "flash_on1");
    night_mode = 1'b0;
    hold_flash(1'b0, 1, "flash_exit");
    hold(AR, 2, "day_ar");
    hold(NSG, 20, "day_nsg_full");
    hold(NSY, 4, "day_nsy");
    hold(AR, 2, "day_ar2");

    // Reset mid EW green.
    hold(EWG, 6, "mid_ewg");
    reset = 1'b0;
    check_state(EWG, "mid_ewg6");
    step();
    reset = 1'b1;
    hold(AR, 2, "mid_rst_ar");
    hold(NSG, 1, "mid_rst_nsg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
